// File: rtl/test_08.sv
`default_nettype none
// ---------------------------------------------------------------------------
// test_08 : serial bit-stream pattern detector, registered one-cycle pulse.
// rev 1.0
// ---------------------------------------------------------------------------
module test_08 #(
   parameter int                     PATTERN_LEN = 4,
   parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1001,
   parameter bit                     OVERLAP     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic x,
   output logic y
);

   localparam int                CNT_W    = $clog2(PATTERN_LEN + 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(PATTERN_LEN);

   logic [PATTERN_LEN-1:0] hist;
   logic [PATTERN_LEN-1:0] next_hist;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       next_cnt;
   logic                   match;

   // The fill counter keeps the zeroed history from matching zero-prefixed patterns.
   always_comb begin
      next_hist = {hist[PATTERN_LEN-2:0], x};
      next_cnt  = (cnt == FULL_CNT) ? cnt : cnt + 1'b1;
      match     = (next_hist == PATTERN) && (next_cnt == FULL_CNT);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hist <= '0;
         cnt  <= '0;
         y    <= 1'b0;
      end else begin
         y <= match;
         if (!OVERLAP && match) begin
            hist <= '0;
            cnt  <= '0;
         end else begin
            hist <= next_hist;
            cnt  <= next_cnt;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_test_08.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_test_08 : directed stimulus against several detector configurations.
// rev 1.0
// ---------------------------------------------------------------------------
module tb_test_08;

   localparam int NI = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          x   = 1'b0;
   logic [NI-1:0] ys;

   int   checks = 0;
   int   errors = 0;

   // Per-instance configuration as seen by the model.
   int          plen [NI] = '{4, 4, 4, 4, 8};
   logic [15:0] pat  [NI] = '{16'h0009, 16'h0009, 16'h0000, 16'h0000, 16'h00A5};
   bit          ovl  [NI] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   bit   stream[$];
   int   start [NI];
   bit   expy  [NI];
   int   pc    [NI];

   always #5 clk = ~clk;

   test_08 #(.PATTERN_LEN(4), .PATTERN(4'b1001), .OVERLAP(1'b1))
      u_d0 (.clk(clk), .rst(rst), .x(x), .y(ys[0]));
   test_08 #(.PATTERN_LEN(4), .PATTERN(4'b1001), .OVERLAP(1'b0))
      u_d1 (.clk(clk), .rst(rst), .x(x), .y(ys[1]));
   test_08 #(.PATTERN_LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b1))
      u_d2 (.clk(clk), .rst(rst), .x(x), .y(ys[2]));
   test_08 #(.PATTERN_LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b0))
      u_d3 (.clk(clk), .rst(rst), .x(x), .y(ys[3]));
   test_08 #(.PATTERN_LEN(8), .PATTERN(8'hA5), .OVERLAP(1'b1))
      u_d4 (.clk(clk), .rst(rst), .x(x), .y(ys[4]));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Match = at least n bits since the last restart point, and the newest n
   // bits of the stream equal the pattern (LSB of pattern = newest bit).
   task automatic step(input bit r, input bit b);
      rst = r;
      x   = b;
      @(posedge clk);
      if (!r) begin
         stream.delete();
         for (int i = 0; i < NI; i++) begin
            start[i] = 0;
            expy[i]  = 1'b0;
         end
      end else begin
         stream.push_back(b);
         for (int i = 0; i < NI; i++) begin
            bit m;
            m = 1'b0;
            if (stream.size() - start[i] >= plen[i]) begin
               m = 1'b1;
               for (int k = 0; k < plen[i]; k++)
                  if (stream[stream.size() - 1 - k] != pat[i][k]) m = 1'b0;
            end
            expy[i] = m;
            if (m && !ovl[i]) start[i] = stream.size();
         end
      end
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("y[%0d] at t=%0t", i, $time), int'(ys[i]), int'(expy[i]));
         pc[i] += int'(ys[i]);
      end
   endtask

   task automatic clear_pc();
      for (int i = 0; i < NI; i++) pc[i] = 0;
   endtask

   task automatic send(input logic [31:0] bits, input int n);
      logic [31:0] v;
      v = bits;
      for (int k = n - 1; k >= 0; k--) step(1'b1, v[k]);
   endtask

   initial begin
      logic [31:0] seq;
      clear_pc();
      #2;

      // Reset hold with toggling input, then fill guard.
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      chk("reset_hold_pulses", pc[0] + pc[1] + pc[2] + pc[3] + pc[4], 0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("fill_guard_pulses", pc[0], 0);

      // Default-pattern stream from a fresh reset.
      step(1'b0, 1'b0);
      clear_pc();
      seq = 32'h0000_1E39;
      send(seq, 16);
      chk("stream16_pulses_d0", pc[0], 1);
      chk("stream16_last_y_d0", int'(ys[0]), 1);

      // Overlapping versus non-overlapping detection.
      step(1'b0, 1'b0);
      clear_pc();
      seq = 32'h0000_0049;
      send(seq, 7);
      chk("overlap_pulses_d0", pc[0], 2);
      chk("nonoverlap_pulses_d1", pc[1], 1);

      // Mid-stream reset discards partial history.
      step(1'b0, 1'b0);
      send(32'h4, 3);
      step(1'b0, 1'b1);
      clear_pc();
      step(1'b1, 1'b1);
      chk("midreset_no_early", int'(ys[0]), 0);
      send(32'h1, 3);
      chk("midreset_match_y", int'(ys[0]), 1);
      chk("midreset_pulses", pc[0], 1);

      // All-zero pattern: nothing before the fourth sampled bit.
      step(1'b0, 1'b0);
      clear_pc();
      send(32'h0, 3);
      chk("zero_guard_d2", pc[2], 0);
      send(32'h0, 1);
      chk("zero_first_d2", int'(ys[2]), 1);
      send(32'h0, 8);
      chk("zero_overlap_pulses", pc[2], 9);
      chk("zero_nonoverlap_pulses", pc[3], 3);

      // Eight-bit pattern.
      step(1'b0, 1'b0);
      clear_pc();
      send(32'h0000_FFA5, 16);
      chk("width8_pulses", pc[4], 1);
      chk("width8_last_y", int'(ys[4]), 1);

      step(1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
